bt_uart_xcvr: RTL and testbench
===============================

// Module: bt_uart_xcvr
// PURPOSE
//  Parametrised full-duplex UART transceiver for the Bluetooth serial module link.
//  Generalises the fixed 8N1 bluetooth block with configurable clock divider, data width,
//  stop bits and an RX FIFO. Sits between the HC-05 pins (rx/tx) and the game logic.
// PARAMETERS
//  CLK_DIV     434  clk_in cycles per bit (50 MHz / 115200); legal range 4..65535
//  DATA_BITS   8    payload bits per frame, LSB first; legal range 5..8
//  STOP_BITS   1    stop bits sent by TX (1 or 2); RX always checks exactly one
//  FIFO_DEPTH  8    RX FIFO entries; must be a power of 2, 2..64
// PORTS
//  clk_in      in   1          system clock; all logic on its rising edge
//  reset       in   1          synchronous, active-low reset
//  rx          in   1          serial input, asynchronous, idle high
//  tx          out  1          serial output, idle high
//  tx_data     in   DATA_BITS  byte to transmit; sampled when enable && !busy
//  enable      in   1          TX request; level, accepted only while busy==0
//  busy        out  1          high from the cycle after acceptance until the stop bit(s) end
//  done        out  1          1-cycle pulse on the cycle busy falls
//  dout        out  DATA_BITS  head of the RX FIFO; valid while avail==1
//  avail       out  1          RX FIFO not empty
//  rd          in   1          pop the FIFO head; ignored when avail==0
//  clk_div     out  1          1-cycle pulse each time the TX bit counter wraps (bit strobe)
//  frame_err   out  1          1-cycle pulse: stop bit sampled low; byte discarded
//  overrun     out  1          1-cycle pulse: byte received while FIFO full; byte discarded
//  parity_err  out  1          1-cycle pulse: parity mismatch (tied 0 without macro)
// BEHAVIOUR
//  Reset (reset==0 at a clk_in edge): tx=1, busy=0, done=0, avail=0, dout=0, clk_div=0,
//   all error pulses 0, FIFO emptied, both FSMs to IDLE. Reset mid-frame aborts the
//   frame; tx is high from the next edge.
//  rx passes through a 2-flop synchroniser (2 cycles latency) before any use.
//  TX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: tx=1; on enable && !busy latch tx_data, busy=1, reset bit counter, go START.
//   - Each non-IDLE state lasts exactly CLK_DIV cycles; clk_div pulses on the last cycle.
//   - START tx=0; DATA shifts DATA_BITS bits LSB first; STOP tx=1 for STOP_BITS bit times.
//   - End of STOP: busy=0 and done=1 on the same cycle; a new request with enable
//     still high is accepted on the following cycle (min. 1 idle cycle between frames).
//   - Frame length = (1 + DATA_BITS + P + STOP_BITS) * CLK_DIV cycles, P = parity bit (0/1).
//  RX FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - IDLE: wait for synchronised falling edge; then count CLK_DIV/2 (floor) cycles.
//   - START: if the line is high at mid-bit it is a glitch -> IDLE, no flags.
//   - DATA/PARITY/STOP: sample every CLK_DIV cycles at mid-bit.
//   - STOP sampled 1 and no parity error: push byte; avail rises the cycle after push.
//   - STOP sampled 0: frame_err, no push. RX returns to IDLE right after the stop
//     sample (half a bit early) to tolerate clock skew.
//  FIFO: dout shows the head combinationally from the registered read pointer.
//   - Push when full: byte dropped, overrun pulse, contents unchanged.
//   - Push and rd on the same cycle when full: pop then push; no overrun.
//   - Push and rd on the same cycle when empty: push only (rd ignored).
//   - Pointers are log2(FIFO_DEPTH)+1 bits wide; wrap naturally.
// CONFIGURATION
//  BT_UART_PARITY_EN defined: an even-parity bit follows the data on TX (P=1).
//   RX checks it; on mismatch parity_err pulses at the stop sample, byte not pushed
//   (frame_err has priority if both occur).
//  BT_UART_PARITY_EN undefined: no parity bit (P=0), PARITY states absent,
//   parity_err tied 0.
// TESTING (CLK_DIV=8, DATA_BITS=8, FIFO_DEPTH=4 unless stated)
//  1 TX 8'hA5, enable 1 cycle -> tx bits 0,1,0,1,0,0,1,0,1,1 each 8 cycles; done after 80 cycles.
//  2 Loop tx->rx, send 8'hAA then 8'hF0 -> avail, dout=AA; rd -> dout=F0; rd -> avail=0.
//  3 Drive 5 frames without rd -> 4 stored, overrun pulses once on 5th, dout=1st byte.
//  4 Frame 8'h3C with stop bit forced 0 -> frame_err 1 pulse, avail stays 0.
//  5 rx low pulse of 3 cycles -> no byte, no flags; reset low mid-TX -> tx=1, busy=0 next cycle.
//  6 With BT_UART_PARITY_EN, send 8'h07 with parity bit 0 -> parity_err pulse, no push.

Source files
------------

// File: rtl/bt_uart_xcvr.sv
// bt_uart_xcvr: full-duplex UART transceiver with an RX FIFO, for the HC-05 link.
// Frame: start, DATA_BITS LSB first, optional even parity, STOP_BITS stop bits.
// Define BT_UART_PARITY_EN to add the even-parity bit on TX and its check on RX.
module bt_uart_xcvr #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 enable,
  output logic                 busy,
  output logic                 done,
  output logic [DATA_BITS-1:0] dout,
  output logic                 avail,
  input  logic                 rd,
  output logic                 clk_div,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 parity_err
);

  localparam int              CW        = $clog2(CLK_DIV);
  localparam int              AW        = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0]   DIV_LAST  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLK_DIV / 2 - 1);
  localparam logic [2:0]      DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]      STOP_LAST = 3'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
`ifdef BT_UART_PARITY_EN
    , TX_PARITY
`endif
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
`ifdef BT_UART_PARITY_EN
    , RX_PARITY
`endif
  } rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t              tx_state, tx_state_n;
  logic [CW-1:0]          tx_cnt, tx_cnt_n;
  logic [2:0]             tx_bit, tx_bit_n;
  logic [DATA_BITS-1:0]   tx_shreg, tx_shreg_n;
  logic                   tx_n, busy_n, done_n;
`ifdef BT_UART_PARITY_EN
  logic                   tx_par, tx_par_n;
`endif

  assign clk_div = (tx_state != TX_IDLE) && (tx_cnt == DIV_LAST);

  // TX state register; tx itself is registered so the pin never glitches
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shreg <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef BT_UART_PARITY_EN
      tx_par   <= 1'b0;
`endif
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      tx_shreg <= tx_shreg_n;
      tx       <= tx_n;
      busy     <= busy_n;
      done     <= done_n;
`ifdef BT_UART_PARITY_EN
      tx_par   <= tx_par_n;
`endif
    end
  end

  // TX next state; tx_n is the line level belonging to the state being entered
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    tx_shreg_n = tx_shreg;
    tx_n       = tx;
    busy_n     = busy;
    done_n     = 1'b0;
`ifdef BT_UART_PARITY_EN
    tx_par_n   = tx_par;
`endif
    case (tx_state)
      TX_IDLE: begin
        tx_n = 1'b1;
        if (enable && !busy) begin
          tx_state_n = TX_START;
          tx_cnt_n   = '0;
          tx_bit_n   = '0;
          tx_shreg_n = tx_data;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
`ifdef BT_UART_PARITY_EN
          tx_par_n   = ^tx_data;
`endif
        end
      end
      default: begin
        if (tx_cnt == DIV_LAST) begin
          tx_cnt_n = '0;
          case (tx_state)
            TX_START: begin
              tx_state_n = TX_DATA;
              tx_bit_n   = '0;
              tx_n       = tx_shreg[0];
            end
            TX_DATA: begin
              if (tx_bit == DATA_LAST) begin
                tx_bit_n = '0;
`ifdef BT_UART_PARITY_EN
                tx_state_n = TX_PARITY;
                tx_n       = tx_par;
`else
                tx_state_n = TX_STOP;
                tx_n       = 1'b1;
`endif
              end else begin
                tx_bit_n   = tx_bit + 3'd1;
                tx_shreg_n = tx_shreg >> 1;
                tx_n       = tx_shreg[1];
              end
            end
`ifdef BT_UART_PARITY_EN
            TX_PARITY: begin
              tx_state_n = TX_STOP;
              tx_n       = 1'b1;
            end
`endif
            TX_STOP: begin
              if (tx_bit == STOP_LAST) begin
                tx_state_n = TX_IDLE;
                tx_bit_n   = '0;
                busy_n     = 1'b0;
                done_n     = 1'b1;
                tx_n       = 1'b1;
              end else begin
                tx_bit_n = tx_bit + 3'd1;
              end
            end
            default: begin
              tx_state_n = TX_IDLE;
              tx_n       = 1'b1;
            end
          endcase
        end else begin
          tx_cnt_n = tx_cnt + 1'b1;
        end
      end
    endcase
  end

  // ---------------- receiver ----------------
  rx_state_t              rx_state, rx_state_n;
  logic [CW-1:0]          rx_cnt, rx_cnt_n;
  logic [2:0]             rx_bit, rx_bit_n;
  logic [DATA_BITS-1:0]   rx_shreg, rx_shreg_n;
  logic                   rx_s1, rx_s2, rx_prev;
  logic                   push;
`ifdef BT_UART_PARITY_EN
  logic                   rx_par, rx_par_n;
`else
  assign parity_err = 1'b0;
`endif

  // RX synchroniser, edge-detect history and state register
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shreg <= '0;
`ifdef BT_UART_PARITY_EN
      rx_par   <= 1'b0;
`endif
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shreg <= rx_shreg_n;
`ifdef BT_UART_PARITY_EN
      rx_par   <= rx_par_n;
`endif
    end
  end

  // RX next state; returns to idle right after the mid-bit stop sample
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt;
    rx_bit_n   = rx_bit;
    rx_shreg_n = rx_shreg;
    push       = 1'b0;
    frame_err  = 1'b0;
`ifdef BT_UART_PARITY_EN
    rx_par_n   = rx_par;
    parity_err = 1'b0;
`endif
    case (rx_state)
      RX_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) rx_state_n = RX_START;
      end
      RX_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = '0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
      default: begin
        if (rx_cnt == DIV_LAST) begin
          rx_cnt_n = '0;
          case (rx_state)
            RX_DATA: begin
              rx_shreg_n = {rx_s2, rx_shreg[DATA_BITS-1:1]};
              if (rx_bit == DATA_LAST) begin
`ifdef BT_UART_PARITY_EN
                rx_state_n = RX_PARITY;
`else
                rx_state_n = RX_STOP;
`endif
              end else begin
                rx_bit_n = rx_bit + 3'd1;
              end
            end
`ifdef BT_UART_PARITY_EN
            RX_PARITY: begin
              rx_par_n   = rx_s2;
              rx_state_n = RX_STOP;
            end
`endif
            RX_STOP: begin
              rx_state_n = RX_IDLE;
              if (!rx_s2) begin
                frame_err = 1'b1;
`ifdef BT_UART_PARITY_EN
              end else if ((^rx_shreg) ^ rx_par) begin
                parity_err = 1'b1;
`endif
              end else begin
                push = 1'b1;
              end
            end
            default: rx_state_n = RX_IDLE;
          endcase
        end else begin
          rx_cnt_n = rx_cnt + 1'b1;
        end
      end
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]          wr_ptr, rd_ptr;
  logic                 empty, full, pop, wr_en;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign avail   = !empty;
  assign pop     = rd && !empty;
  // a pop on the same cycle frees the slot, so a full FIFO still accepts
  assign wr_en   = push && (!full || pop);
  assign overrun = push && full && !pop;
  assign dout    = avail ? mem[rd_ptr[AW-1:0]] : '0;

  // FIFO pointers
  always_ff @(posedge clk_in) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // FIFO storage; not reset because dout is masked while empty
  always_ff @(posedge clk_in) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx_shreg;
  end

endmodule

// File: tb/tb_bt_uart_xcvr.sv
// Self-checking bench for bt_uart_xcvr (CLK_DIV=8, DATA_BITS=8, FIFO_DEPTH=4).
module tb_bt_uart_xcvr;
  localparam int CLK_DIV    = 8;
  localparam int FIFO_DEPTH = 4;
`ifdef BT_UART_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 10 + P;

  logic       clk_in = 1'b0;
  logic       reset, rx, tx, enable, busy, done, avail, rd, clk_div;
  logic       frame_err, overrun, parity_err, rx_drv, loop_en;
  logic [7:0] tx_data, dout;

  assign rx = loop_en ? tx : rx_drv;
  always #5 clk_in = ~clk_in;

  bt_uart_xcvr #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_in(clk_in), .reset(reset), .rx(rx), .tx(tx), .tx_data(tx_data), .enable(enable),
    .busy(busy), .done(done), .dout(dout), .avail(avail), .rd(rd), .clk_div(clk_div),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  int n_tests = 0, n_fail = 0;
  int n_ferr = 0, n_ovr = 0, n_perr = 0;
  logic cap_q[$];
  logic [7:0] mdl_q[$];

  // pulse counters sampled away from the active edge
  always @(negedge clk_in) begin
    if (frame_err === 1'b1)  n_ferr++;
    if (overrun === 1'b1)    n_ovr++;
    if (parity_err === 1'b1) n_perr++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // drive one frame on rx_drv: start, 8 data LSB first, [parity], stop, then idle
  task automatic send_rx(input logic [7:0] d, input logic stop_b, input logic par_ok);
    logic [7:0] dd;
    dd = d;
    rx_drv = 1'b0;
    ticks(CLK_DIV);
    for (int i = 0; i < 8; i++) begin
      rx_drv = dd[0];
      dd = dd >> 1;
      ticks(CLK_DIV);
    end
    if (P == 1) begin
      rx_drv = (^d) ^ ~par_ok;
      ticks(CLK_DIV);
    end
    rx_drv = stop_b;
    ticks(CLK_DIV);
    rx_drv = 1'b1;
    ticks(2 * CLK_DIV);
  endtask

  // request one TX frame, capture tx at every mid-bit, wait (bounded) for done
  task automatic tx_frame(input logic [7:0] d, output int cyc, output int strobes);
    cap_q.delete();
    tx_data = d;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    cyc = 0;
    strobes = 0;
    while (!done && cyc < 400) begin
      if ((cyc % CLK_DIV) == CLK_DIV / 2 && cap_q.size() < 16) cap_q.push_back(tx);
      if (clk_div) strobes++;
      tick();
      cyc++;
    end
  endtask

  task automatic pop_check(input logic [7:0] exp);
    check("fifo_head", dout, exp);
    rd = 1'b1;
    tick();
    rd = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;   // wire order, bit 0 first (start ... stop), no parity
  } tx_vec_t;

  typedef struct {
    logic [7:0] data;
    logic       stop_b;
    int         ferr;
    int         ovr;
    logic       av;
    logic [7:0] head;
  } rx_vec_t;

  tx_vec_t txv[4];
  rx_vec_t rxv[8];

  initial begin
    int cyc, strobes, bf, bo, bp, exp_ovr, exp_perr, pops;
    logic [9:0] ln;
    logic [7:0] dd;
    logic [7:0] rb;
    logic exp_b, got_b;

    txv[0] = '{8'hA5, 10'b1101001010};
    txv[1] = '{8'h00, 10'b1000000000};
    txv[2] = '{8'hFF, 10'b1111111110};
    txv[3] = '{8'h3C, 10'b1001111000};

    rxv[0] = '{8'h3C, 1'b0, 1, 0, 1'b0, 8'h00};
    rxv[1] = '{8'h11, 1'b1, 0, 0, 1'b1, 8'h11};
    rxv[2] = '{8'hA5, 1'b0, 1, 0, 1'b1, 8'h11};
    rxv[3] = '{8'h22, 1'b1, 0, 0, 1'b1, 8'h11};
    rxv[4] = '{8'h33, 1'b1, 0, 0, 1'b1, 8'h11};
    rxv[5] = '{8'h44, 1'b1, 0, 0, 1'b1, 8'h11};
    rxv[6] = '{8'h55, 1'b1, 0, 1, 1'b1, 8'h11};
    rxv[7] = '{8'h66, 1'b0, 1, 0, 1'b1, 8'h11};

    exp_perr = 0;
    reset = 1'b0; enable = 1'b0; rd = 1'b0; tx_data = '0; rx_drv = 1'b1; loop_en = 1'b0;
    ticks(3);
    check("rst_tx", tx, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_avail", avail, 0);
    check("rst_dout", dout, 0);
    check("rst_clk_div", clk_div, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_parity_err", parity_err, 0);
    reset = 1'b1;
    ticks(2);

    // transmit table
    for (int v = 0; v < 4; v++) begin
      tx_frame(txv[v].data, cyc, strobes);
      check("tx_frame_len", cyc, NB * CLK_DIV);
      check("tx_strobes", strobes, NB);
      check("tx_done", done, 1);
      check("tx_busy_fell", busy, 0);
      ln = txv[v].line;
      dd = txv[v].data;
      for (int k = 0; k < NB; k++) begin
        if (P == 1 && k == 9) exp_b = ^dd;
        else begin
          exp_b = ln[0];
          ln = ln >> 1;
        end
        got_b = (k < cap_q.size()) ? cap_q[k] : 1'bx;
        check($sformatf("tx_bit%0d_%02h", k, dd), got_b, exp_b);
      end
      tick();
      check("done_one_cycle", done, 0);
    end

    // receive table, no reads: error frames, fill, overrun
    for (int v = 0; v < 8; v++) begin
      bf = n_ferr;
      bo = n_ovr;
      send_rx(rxv[v].data, rxv[v].stop_b, 1'b1);
      check($sformatf("rx%0d_frame_err", v), n_ferr - bf, rxv[v].ferr);
      check($sformatf("rx%0d_overrun", v), n_ovr - bo, rxv[v].ovr);
      check($sformatf("rx%0d_avail", v), avail, rxv[v].av);
      if (rxv[v].av) check($sformatf("rx%0d_dout", v), dout, rxv[v].head);
    end
    pop_check(8'h11);
    pop_check(8'h22);
    pop_check(8'h33);
    pop_check(8'h44);
    check("drained_avail", avail, 0);

    // loopback AA, F0 then read both
    loop_en = 1'b1;
    tx_frame(8'hAA, cyc, strobes);
    tx_frame(8'hF0, cyc, strobes);
    tick();
    check("loop_avail", avail, 1);
    pop_check(8'hAA);
    pop_check(8'hF0);
    check("loop_empty", avail, 0);

    // random loopback against a queue model of the FIFO
    exp_ovr = n_ovr;
    for (int it = 0; it < 25; it++) begin
      rb = 8'($urandom);
      tx_frame(rb, cyc, strobes);
      tick();
      if (mdl_q.size() < FIFO_DEPTH) mdl_q.push_back(rb);
      else exp_ovr++;
      check("rand_avail", avail, (mdl_q.size() != 0));
      check("rand_overrun_count", n_ovr, exp_ovr);
      pops = $urandom_range(0, 1);
      for (int j = 0; j < pops; j++)
        if (mdl_q.size() > 0) pop_check(mdl_q.pop_front());
    end
    while (mdl_q.size() > 0) pop_check(mdl_q.pop_front());
    check("rand_drained", avail, 0);
    loop_en = 1'b0;
    ticks(4);

    // 3-cycle low glitch on rx
    bf = n_ferr;
    bo = n_ovr;
    bp = n_perr;
    rx_drv = 1'b0;
    ticks(3);
    rx_drv = 1'b1;
    ticks(40);
    check("glitch_avail", avail, 0);
    check("glitch_frame_err", n_ferr - bf, 0);
    check("glitch_overrun", n_ovr - bo, 0);
    check("glitch_parity_err", n_perr - bp, 0);

`ifdef BT_UART_PARITY_EN
    bp = n_perr;
    bf = n_ferr;
    send_rx(8'h07, 1'b1, 1'b0);
    exp_perr++;
    check("par_err_pulse", n_perr - bp, 1);
    check("par_err_no_ferr", n_ferr - bf, 0);
    check("par_err_no_push", avail, 0);
    send_rx(8'h07, 1'b1, 1'b1);
    check("par_ok_avail", avail, 1);
    pop_check(8'h07);
`endif

    // reset mid-frame with a byte in the FIFO
    send_rx(8'h5A, 1'b1, 1'b1);
    check("pre_rst_avail", avail, 1);
    tx_data = 8'h00;
    enable = 1'b1;
    tick();
    enable = 1'b0;
    ticks(20);
    check("mid_tx_busy", busy, 1);
    check("mid_tx_line", tx, 0);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_avail", avail, 0);
    check("midrst_clk_div", clk_div, 0);
    ticks(20);
    check("post_rst_tx_idle", tx, 1);
    check("post_rst_busy_idle", busy, 0);

    check("parity_err_total", n_perr, exp_perr);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
